tube_event_builder: RTL and testbench

//  Parametrised successor to the fixed 32-tube readout sequencer. It waits for a scintillator coincidence
//  and opens a drift window. It records the first-hit time of each of N_CH tube channels, then frames
//  the event into the 16-bit RPi readout FIFO as a header, hit words and a trailer.

---
 rtl/tube_event_builder.sv | 139 +++++++++++++
 tb/tb_tube_event_builder.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/tube_event_builder.sv
// tube_event_builder: coincidence-triggered drift-tube event framer for the 16-bit readout FIFO.
// Ports:
//   clk50         system clock, all signals sampled on its rising edge
//   clr_n         synchronous reset, active low
//   scin_coin     scintillator coincidence (synchronous)
//   tube_hit      per-tube discriminator levels (synchronous)
//   fifo_wr_count current FIFO occupancy in words
//   fifo_full     FIFO full flag, stalls the write in progress
//   fifo_din      word to write: header {evt,FE}, hit {time,id}, trailer FFFF
//   fifo_wr_en    write strobe, fifo_din valid in the same cycle
//   busy          high whenever the sequencer is not idle
//   evt_num       events written, wrapping
//   drop_cnt      events dropped for lack of FIFO space, saturating
module tube_event_builder #(
    parameter int N_CH          = 32,
    parameter int TIME_W        = 8,
    parameter int WINDOW        = 255,
    parameter int ZERO_SUPPRESS = 1,
    parameter int FIFO_DEPTH    = 1024,
    parameter int CNT_W         = 10,
    parameter int HOLDOFF       = 11
) (
    input  logic              clk50,
    input  logic              clr_n,
    input  logic              scin_coin,
    input  logic [N_CH-1:0]   tube_hit,
    input  logic [CNT_W-1:0]  fifo_wr_count,
    input  logic              fifo_full,
    output logic [15:0]       fifo_din,
    output logic              fifo_wr_en,
    output logic              busy,
    output logic [7:0]        evt_num,
    output logic [15:0]       drop_cnt
);
    typedef enum logic [2:0] {S_IDLE, S_ACQ, S_CHECK, S_DROP, S_HDR, S_CH, S_TRL, S_CLR} state_t;
    state_t            state_q;
    logic              scin_q;
    logic [7:0]        tcnt_q;
    logic [7:0]        idx_q;
    logic [15:0]       hold_q;
    logic [7:0]        evt_q;
    logic [15:0]       drop_q;
    logic [TIME_W-1:0] hit_q [N_CH];
    logic [TIME_W-1:0] cur_t;
    logic [8:0]        start;
    logic [8:0]        nhits;
    logic [7:0]        nxt_idx;
    logic              nxt_found;
    logic              too_full;
    logic [31:0]       need;
    assign evt_num  = evt_q;
    assign drop_cnt = drop_q;
    // nxt_idx is the next channel to emit at or after start; with zero
    // suppression empty channels are skipped here so they cost no cycle.
    always_comb begin
        start     = state_q == S_CH ? {1'b0, idx_q} + 9'd1 : 9'd0;
        nhits     = '0;
        nxt_found = 1'b0;
        nxt_idx   = '0;
        cur_t     = '0;
        for (int i = N_CH - 1; i >= 0; i--) begin
            nhits = nhits + {8'd0, |hit_q[i]};
            if (idx_q == 8'(i))
                cur_t = hit_q[i];
            if (9'(i) >= start && (ZERO_SUPPRESS == 0 || hit_q[i] != '0)) begin
                nxt_found = 1'b1;
                nxt_idx   = 8'(i);
            end
        end
        need       = 32'd2 + (ZERO_SUPPRESS != 0 ? 32'(nhits) : 32'(N_CH));
        too_full   = 32'(fifo_wr_count) + need > 32'(FIFO_DEPTH);
        // the strobe must react to fifo_full in the same cycle, so it is decoded from state
        fifo_wr_en = (state_q == S_HDR || state_q == S_CH || state_q == S_TRL) && !fifo_full;
        fifo_din   = state_q == S_HDR ? {evt_q, 8'hFE} :
                     state_q == S_CH  ? {cur_t, idx_q} :
                     state_q == S_TRL ? 16'hFFFF : 16'h0000;
        busy       = state_q != S_IDLE;
    end
    always_ff @(posedge clk50) begin
        if (!clr_n) begin
            state_q <= S_IDLE;
            scin_q  <= 1'b0;
            tcnt_q  <= '0;
            idx_q   <= '0;
            hold_q  <= '0;
            evt_q   <= '0;
            drop_q  <= '0;
            for (int i = 0; i < N_CH; i++)
                hit_q[i] <= '0;
        end else begin
            // tracks in every state so a held coincidence never looks like a new edge
            scin_q <= scin_coin;
            case (state_q)
                S_IDLE: if (scin_coin && !scin_q) begin
                    state_q <= S_ACQ;
                    tcnt_q  <= 8'd1;
                    for (int i = 0; i < N_CH; i++)
                        hit_q[i] <= '0;
                end
                S_ACQ: begin
                    // zero means "no hit yet", so only the first hit lands
                    for (int i = 0; i < N_CH; i++)
                        if (tube_hit[i] && hit_q[i] == '0)
                            hit_q[i] <= tcnt_q;
                    tcnt_q <= tcnt_q + 8'd1;
                    if (tcnt_q == 8'(WINDOW))
                        state_q <= S_CHECK;
                end
                S_CHECK: state_q <= too_full ? S_DROP : S_HDR;
                S_DROP: begin
                    drop_q  <= drop_q + {15'd0, drop_q != 16'hFFFF};
                    state_q <= S_CLR;
                    hold_q  <= 16'(HOLDOFF - 1);
                end
                S_HDR: if (fifo_wr_en) begin
                    state_q <= nxt_found ? S_CH : S_TRL;
                    idx_q   <= nxt_idx;
                end
                S_CH: if (fifo_wr_en) begin
                    if (nxt_found)
                        idx_q <= nxt_idx;
                    else
                        state_q <= S_TRL;
                end
                S_TRL: if (fifo_wr_en) begin
                    evt_q   <= evt_q + 8'd1;
                    state_q <= S_CLR;
                    hold_q  <= 16'(HOLDOFF - 1);
                end
                S_CLR: begin
                    hold_q <= hold_q - 16'd1;
                    if (hold_q == 16'd0)
                        state_q <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_tube_event_builder.sv
// tb_tube_event_builder: table-driven and scoreboard checks of tube_event_builder in two configurations.
module tb_tube_event_builder;
    logic clk50 = 1'b0;
    always #5 clk50 = ~clk50;

    logic        rst_a_n, scin_a, full_a, wr_a, busy_a;
    logic [31:0] hit_a;
    logic [9:0]  cnt_a;
    logic [15:0] din_a, drop_a;
    logic [7:0]  evt_a;

    logic        rst_b_n, scin_b, full_b, wr_b, busy_b;
    logic [3:0]  hit_b;
    logic [9:0]  cnt_b;
    logic [15:0] din_b, drop_b;
    logic [7:0]  evt_b;

    tube_event_builder u_a (
        .clk50(clk50), .clr_n(rst_a_n), .scin_coin(scin_a), .tube_hit(hit_a),
        .fifo_wr_count(cnt_a), .fifo_full(full_a), .fifo_din(din_a), .fifo_wr_en(wr_a),
        .busy(busy_a), .evt_num(evt_a), .drop_cnt(drop_a)
    );

    tube_event_builder #(.N_CH(4), .WINDOW(8), .ZERO_SUPPRESS(0), .HOLDOFF(2)) u_b (
        .clk50(clk50), .clr_n(rst_b_n), .scin_coin(scin_b), .tube_hit(hit_b),
        .fifo_wr_count(cnt_b), .fifo_full(full_b), .fifo_din(din_b), .fifo_wr_en(wr_b),
        .busy(busy_b), .evt_num(evt_b), .drop_cnt(drop_b)
    );

    typedef struct {
        int ch_a; int t_a; int ch_b; int t_b; int nfill; int cnt; bit exp_drop;
    } vec_t;

    int          n_vec = 0;
    int          n_err = 0;
    logic [15:0] q_a[$];
    logic [15:0] q_b[$];
    logic [7:0]  evt_a_m = 8'd0;
    logic [7:0]  evt_b_m = 8'd0;
    logic [15:0] drop_a_m = 16'd0;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got %h expected %h", name, got, exp);
        end
    endtask

    always @(negedge clk50) if (wr_a === 1'b1) begin
        if (q_a.size() == 0) begin
            n_vec++; n_err++;
            $display("FAIL unexpected_write_a got %h expected no write", din_a);
        end else
            chk("word_a", 32'(din_a), 32'(q_a.pop_front()));
    end

    always @(negedge clk50) if (wr_b === 1'b1) begin
        if (q_b.size() == 0) begin
            n_vec++; n_err++;
            $display("FAIL unexpected_write_b got %h expected no write", din_b);
        end else
            chk("word_b", 32'(din_b), 32'(q_b.pop_front()));
    end

    task automatic tick();
        @(posedge clk50);
        #1;
    endtask

    task automatic wait_idle(input bit b, input string name);
        int k = 0;
        while ((b ? busy_b : busy_a) !== 1'b0 && k < 2000) begin
            @(negedge clk50);
            k++;
        end
        chk(name, 32'(b ? busy_b : busy_a), 32'd0);
    endtask

    function automatic logic [31:0] pat(input vec_t v, input int k);
        logic [31:0] p = '0;
        if (k == v.t_a) p[v.ch_a] = 1'b1;
        if (k == v.t_b) p[v.ch_b] = 1'b1;
        if (k == 100) for (int i = 0; i < v.nfill; i++) p[2 + i] = 1'b1;
        return p;
    endfunction

    // first-hit-wins model: expected words queued before the stimulus is driven
    task automatic push_a(input vec_t v);
        logic [7:0]  tm [32];
        logic [31:0] p;
        for (int i = 0; i < 32; i++) tm[i] = 8'd0;
        for (int k = 1; k <= 255; k++) begin
            p = pat(v, k);
            for (int i = 0; i < 32; i++) if (tm[i] == 8'd0 && p[i]) tm[i] = 8'(k);
        end
        if (!v.exp_drop) begin
            q_a.push_back({evt_a_m, 8'hFE});
            for (int i = 0; i < 32; i++) if (tm[i] != 8'd0) q_a.push_back({tm[i], 8'(i)});
            q_a.push_back(16'hFFFF);
            evt_a_m++;
        end else if (drop_a_m != 16'hFFFF)
            drop_a_m++;
    endtask

    task automatic drive_a(input vec_t v, input bit hold);
        cnt_a = 10'(v.cnt);
        tick(); scin_a = 1'b1;
        for (int k = 1; k <= 255; k++) begin
            tick(); hit_a = pat(v, k);
        end
        tick(); hit_a = '0;
        if (!hold) scin_a = 1'b0;
    endtask

    task automatic finish_a();
        wait_idle(1'b0, "idle_a");
        chk("queue_empty_a", 32'(q_a.size()), 32'd0);
        chk("evt_num_a", 32'(evt_a), 32'(evt_a_m));
        chk("drop_cnt_a", 32'(drop_a), 32'(drop_a_m));
        cnt_a = '0;
    endtask

    task automatic run_a(input vec_t v, input bit hold);
        push_a(v);
        drive_a(v, hold);
        finish_a();
    endtask

    task automatic wait_hdr_a();
        int k = 0;
        do begin
            @(negedge clk50);
            k++;
        end while (wr_a !== 1'b1 && k < 600);
        chk("hdr_seen_a", 32'(wr_a), 32'd1);
    endtask

    task automatic run_b(input int ch, input int t);
        q_b.push_back({evt_b_m, 8'hFE});
        for (int i = 0; i < 4; i++) q_b.push_back({(i == ch && t != 0) ? 8'(t) : 8'h00, 8'(i)});
        q_b.push_back(16'hFFFF);
        evt_b_m++;
        tick(); scin_b = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            tick(); hit_b = (k == t) ? 4'(1 << ch) : 4'd0;
        end
        tick(); hit_b = '0; scin_b = 1'b0;
        wait_idle(1'b1, "idle_b");
        chk("queue_empty_b", 32'(q_b.size()), 32'd0);
        chk("evt_num_b", 32'(evt_b), 32'(evt_b_m));
    endtask

    initial begin
        vec_t vecs[8];
        vec_t vs;
        int   nb;
        vecs[0] = '{3, 5, 3, 9, 0, 0, 1'b0};
        vecs[1] = '{0, 1, 31, 255, 0, 0, 1'b0};
        vecs[2] = '{7, 20, 2, 20, 0, 500, 1'b0};
        vecs[3] = '{0, 1, 1, 2, 28, 1000, 1'b1};
        vecs[4] = '{0, 1, 1, 2, 28, 992, 1'b0};
        vecs[5] = '{0, 1, 1, 2, 28, 993, 1'b1};
        vecs[6] = '{0, 0, 0, 0, 0, 1022, 1'b0};
        vecs[7] = '{0, 0, 0, 0, 0, 1023, 1'b1};

        rst_a_n = 1'b0; scin_a = 1'b0; full_a = 1'b0; hit_a = '0; cnt_a = '0;
        rst_b_n = 1'b0; scin_b = 1'b0; full_b = 1'b0; hit_b = '0; cnt_b = '0;
        repeat (3) tick();
        @(negedge clk50);
        chk("rst_wr_en_a", 32'(wr_a), 32'd0);
        chk("rst_busy_a", 32'(busy_a), 32'd0);
        chk("rst_din_a", 32'(din_a), 32'd0);
        chk("rst_evt_a", 32'(evt_a), 32'd0);
        chk("rst_drop_a", 32'(drop_a), 32'd0);
        chk("rst_busy_b", 32'(busy_b), 32'd0);
        chk("rst_evt_b", 32'(evt_b), 32'd0);
        tick(); rst_a_n = 1'b1; rst_b_n = 1'b1;
        tick();

        for (int i = 0; i < 8; i++) run_a(vecs[i], 1'b0);

        // stall on the first hit word: it must be held and written exactly once
        vs = '{3, 5, 9, 6, 0, 0, 1'b0};
        push_a(vs);
        drive_a(vs, 1'b0);
        wait_hdr_a();
        tick(); full_a = 1'b1;
        repeat (3) begin
            @(negedge clk50);
            chk("stall_wr_en", 32'(wr_a), 32'd0);
            chk("stall_din", 32'(din_a), 32'h0503);
            tick();
        end
        full_a = 1'b0;
        finish_a();

        // coincidence held high through CLEAR must not start a second event
        run_a(vecs[0], 1'b1);
        nb = 0;
        repeat (20) begin
            @(negedge clk50);
            if (busy_a) nb++;
        end
        chk("no_retrigger", 32'(nb), 32'd0);
        tick(); scin_a = 1'b0;
        tick();

        // reset in the middle of the hit-word scan
        vs = '{1, 2, 5, 3, 0, 0, 1'b0};
        vs.nfill = 0;
        push_a(vs);
        drive_a(vs, 1'b0);
        wait_hdr_a();
        tick(); rst_a_n = 1'b0;
        tick(); rst_a_n = 1'b1;
        q_a.delete();
        evt_a_m = 8'd0;
        drop_a_m = 16'd0;
        @(negedge clk50);
        chk("midrst_busy", 32'(busy_a), 32'd0);
        chk("midrst_wr_en", 32'(wr_a), 32'd0);
        chk("midrst_evt", 32'(evt_a), 32'd0);
        chk("midrst_drop", 32'(drop_a), 32'd0);
        run_a(vecs[0], 1'b0);

        // no-suppression config: empty event writes every channel, then wrap evt_num
        run_b(0, 0);
        for (int e = 1; e < 256; e++) run_b(e % 4, 1 + e % 8);
        chk("evt_wrap_b", 32'(evt_b), 32'd0);
        chk("drop_b", 32'(drop_b), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #900000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end
endmodule
